// File: rtl/apb_obi_bridge_pkg.sv
// Shared types and helpers for the APB-to-OBI bridge.
// Latency: n/a (package).
// Backpressure: n/a (package).
package apb_obi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RESP,
        DONE,
        DRAIN
    } bridge_state_e;

    // Default response timeout in cycles, and the counter width it needs.
    localparam int TIMEOUT_DFLT = 256;
    localparam int CNT_W_DFLT   = $clog2(TIMEOUT_DFLT + 1);

    // Counter width for a given timeout; never below one bit so a
    // disabled timeout (0) still elaborates.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    // OBI handshake signals travel with an inverted copy (odd parity).
    function automatic logic odd_par(input logic sig);
        return ~sig;
    endfunction

    function automatic logic par_ok(input logic sig, input logic par);
        return par == odd_par(sig);
    endfunction

endpackage

// File: rtl/apb_obi_timeout_cnt.sv
// Response timeout counter: clear / count-enable, flags the last allowed cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; TIMEOUT=0 disables expiry entirely.
// Ports: clk, reset (async, active-high), clr, en -> expired.
module apb_obi_timeout_cnt
    import apb_obi_bridge_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIM = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt == LIM);

endmodule

// File: rtl/apb_to_obi_bridge.sv
// APB completer to single-outstanding OBI manager, one OBI transaction per APB transfer.
// Latency: setup T0, req T1, rvalid T2 earliest, PREADY T3 (4-cycle APB transfer minimum).
// Backpressure: APB stalls via PREADY=0 until OBI gnt and rvalid (or response timeout).
// Ports: APB completer (PSEL..PSLVERR), OBI manager (obi_* with parity), par_err pulse.
module apb_to_obi_bridge
    import apb_obi_bridge_pkg::*;
#(
    parameter int          APB_AW      = 32,
    parameter int          APB_DW      = 32,
    parameter int          OBI_AW      = 32,
    parameter int          OBI_DW      = 32,
    parameter int          OBI_IDW     = 1,
    parameter logic [31:0] ADDR_OFFSET = 32'h0000_0000,
    parameter int          TIMEOUT     = TIMEOUT_DFLT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_AW-1:0]     PADDR,
    input  logic [APB_DW-1:0]     PWDATA,
    input  logic [APB_DW/8-1:0]   PSTRB,
    output logic [APB_DW-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  obi_req,
    output logic                  obi_reqpar,
    output logic [OBI_AW-1:0]     obi_addr,
    output logic                  obi_we,
    output logic [OBI_DW/8-1:0]   obi_be,
    output logic [OBI_DW-1:0]     obi_wdata,
    output logic [OBI_IDW-1:0]    obi_aid,
    input  logic                  obi_gnt,
    input  logic                  obi_gntpar,
    input  logic                  obi_rvalid,
    input  logic                  obi_rvalidpar,
    output logic                  obi_rready,
    output logic                  obi_rreadypar,
    input  logic [OBI_DW-1:0]     obi_rdata,
    input  logic                  obi_err,
    input  logic [OBI_IDW-1:0]    obi_rid,
    output logic                  par_err
);

    if (APB_DW != OBI_DW) begin : g_dw_check
        $error("apb_to_obi_bridge: APB_DW must equal OBI_DW");
    end

    localparam int SW = (APB_AW > OBI_AW) ? APB_AW : OBI_AW;

    bridge_state_e state;
    logic          par_flag;   // sticky parity error for the current transfer
    logic          drain;      // a timed-out response is still owed by the fabric
    logic          tmo_hit;
    logic          par_chk;
    logic          par_bad;
    logic [SW-1:0] addr_sum;
    logic          unused_rid;

    assign addr_sum   = SW'(PADDR) + SW'(ADDR_OFFSET);
    assign obi_aid    = '0;
    assign unused_rid = ^obi_rid;

    assign par_chk = (state == ADDR) || (state == RESP) || (state == DRAIN);
    assign par_bad = !par_ok(obi_gnt, obi_gntpar) || !par_ok(obi_rvalid, obi_rvalidpar);

    apb_obi_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clr     (state != RESP),
        .en      ((state == RESP) && !obi_rvalid),
        .expired (tmo_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            PRDATA        <= '0;
            PREADY        <= 1'b0;
            PSLVERR       <= 1'b0;
            obi_req       <= 1'b0;
            obi_reqpar    <= 1'b1;
            obi_addr      <= '0;
            obi_we        <= 1'b0;
            obi_be        <= '0;
            obi_wdata     <= '0;
            obi_rready    <= 1'b0;
            obi_rreadypar <= 1'b1;
            par_err       <= 1'b0;
            par_flag      <= 1'b0;
            drain         <= 1'b0;
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            par_err <= par_chk && par_bad;
            if (par_chk && par_bad) begin
                par_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    par_flag <= 1'b0;
                    if (PSEL && !PENABLE) begin
                        obi_addr   <= addr_sum[OBI_AW-1:0];
                        obi_we     <= PWRITE;
                        obi_wdata  <= PWDATA;
                        obi_be     <= PWRITE ? PSTRB : '1;
                        obi_req    <= 1'b1;
                        obi_reqpar <= odd_par(1'b1);
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (obi_gnt) begin
                        obi_req       <= 1'b0;
                        obi_reqpar    <= odd_par(1'b0);
                        obi_rready    <= 1'b1;
                        obi_rreadypar <= odd_par(1'b1);
                        state         <= RESP;
                    end
                end
                RESP: begin
                    // A response on the last allowed cycle still wins over expiry.
                    if (obi_rvalid) begin
                        PRDATA        <= obi_we ? '0 : obi_rdata;
                        PSLVERR       <= obi_err || par_flag || par_bad;
                        PREADY        <= 1'b1;
                        obi_rready    <= 1'b0;
                        obi_rreadypar <= odd_par(1'b0);
                        state         <= DONE;
                    end else if (tmo_hit) begin
                        PRDATA  <= '0;
                        PSLVERR <= 1'b1;
                        PREADY  <= 1'b1;
                        drain   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // rready stays high while draining, so a stale response
                    // landing here is accepted and the drain is already over.
                    if (drain && obi_rvalid) begin
                        drain         <= 1'b0;
                        obi_rready    <= 1'b0;
                        obi_rreadypar <= odd_par(1'b0);
                        state         <= IDLE;
                    end else if (drain) begin
                        state <= DRAIN;
                    end else begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (obi_rvalid) begin
                        drain         <= 1'b0;
                        obi_rready    <= 1'b0;
                        obi_rreadypar <= odd_par(1'b0);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// Bench for apb_to_obi_bridge: APB master plus OBI responder against a transfer-level model.
// Latency: checks req-phase and response-phase cycle counts per transfer.
// Backpressure: randomized gnt/rvalid delays, timeout, drain, parity and reset cases.
module tb_apb_to_obi_bridge;

    localparam logic [31:0] OFFS = 32'h0000_1000;
    localparam int          TMO  = 4;

    logic        clk;
    logic        reset;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic        PREADY, PSLVERR;
    logic        obi_req, obi_reqpar, obi_we;
    logic [31:0] obi_addr, obi_wdata, obi_rdata;
    logic [3:0]  obi_be;
    logic [0:0]  obi_aid, obi_rid;
    logic        obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar;
    logic        obi_rready, obi_rreadypar, obi_err, par_err;

    int n_cmp = 0;
    int n_mis = 0;

    apb_to_obi_bridge #(
        .ADDR_OFFSET (OFFS),
        .TIMEOUT     (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PSTRB         (PSTRB),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .obi_req       (obi_req),
        .obi_reqpar    (obi_reqpar),
        .obi_addr      (obi_addr),
        .obi_we        (obi_we),
        .obi_be        (obi_be),
        .obi_wdata     (obi_wdata),
        .obi_aid       (obi_aid),
        .obi_gnt       (obi_gnt),
        .obi_gntpar    (obi_gntpar),
        .obi_rvalid    (obi_rvalid),
        .obi_rvalidpar (obi_rvalidpar),
        .obi_rready    (obi_rready),
        .obi_rreadypar (obi_rreadypar),
        .obi_rdata     (obi_rdata),
        .obi_err       (obi_err),
        .obi_rid       (obi_rid),
        .par_err       (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full APB transfer with the OBI side answering after gd/rd cycles.
    // rd beyond the timeout means the fabric never responds (to=1).
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int gd, input int rd,
                        input logic [31:0] rdat, input bit e, input bit bp, input bit to);
        int n;
        int pe;
        bit stable;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        pe       = 0;
        stable   = 1'b1;
        exp_addr = a + OFFS;
        exp_be   = wr ? s : 4'hF;

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        tick();
        PENABLE = 1'b1;
        PADDR   = $urandom;
        PWDATA  = $urandom;
        check("req_up", 32'(obi_req), 32'd1);
        check("reqpar_up", 32'(obi_reqpar), 32'd0);
        check("addr", obi_addr, exp_addr);
        check("we", 32'(obi_we), 32'(wr));
        check("be", 32'(obi_be), 32'(exp_be));
        if (wr) check("wdata", obi_wdata, d);

        n = 0;
        while (obi_req && n < 50) begin
            if (obi_addr !== exp_addr || obi_be !== exp_be || obi_we !== wr) stable = 1'b0;
            if (n == gd) begin
                obi_gnt    = 1'b1;
                obi_gntpar = bp ? 1'b1 : 1'b0;
            end
            tick();
            pe += int'(par_err);
            obi_gnt    = 1'b0;
            obi_gntpar = 1'b1;
            n++;
        end
        check("req_cycles", 32'(n), 32'(gd + 1));
        check("addr_stable", 32'(stable), 32'd1);
        check("rready_resp", 32'(obi_rready), 32'd1);
        check("rreadypar_resp", 32'(obi_rreadypar), 32'd0);

        n = 0;
        while (!PREADY && n < 50) begin
            if (n == rd) begin
                obi_rvalid    = 1'b1;
                obi_rvalidpar = 1'b0;
                obi_rdata     = rdat;
                obi_err       = e;
            end
            tick();
            pe += int'(par_err);
            obi_rvalid    = 1'b0;
            obi_rvalidpar = 1'b1;
            obi_err       = 1'b0;
            obi_rdata     = $urandom;
            n++;
        end
        check("resp_cycles", 32'(n), to ? 32'(TMO) : 32'(rd + 1));
        check("prdata", PRDATA, (to || wr) ? 32'h0 : rdat);
        check("pslverr", 32'(PSLVERR), 32'(e | bp | to));
        check("rready_done", 32'(obi_rready), 32'(to));

        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        pe += int'(par_err);
        check("pready_pulse", 32'(PREADY), 32'd0);
        check("pslverr_clr", 32'(PSLVERR), 32'd0);
        check("par_err_cnt", 32'(pe), 32'(bp));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pready"}, 32'(PREADY), 32'd0);
        check({tag, "_pslverr"}, 32'(PSLVERR), 32'd0);
        check({tag, "_prdata"}, PRDATA, 32'h0);
        check({tag, "_req"}, 32'(obi_req), 32'd0);
        check({tag, "_reqpar"}, 32'(obi_reqpar), 32'd1);
        check({tag, "_rready"}, 32'(obi_rready), 32'd0);
        check({tag, "_rreadypar"}, 32'(obi_rreadypar), 32'd1);
        check({tag, "_addr"}, obi_addr, 32'h0);
        check({tag, "_we_be"}, 32'({obi_we, obi_be}), 32'h0);
        check({tag, "_wdata"}, obi_wdata, 32'h0);
        check({tag, "_par_err"}, 32'(par_err), 32'd0);
        check({tag, "_aid"}, 32'(obi_aid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        obi_gnt = 1'b0; obi_gntpar = 1'b1;
        obi_rvalid = 1'b0; obi_rvalidpar = 1'b1;
        obi_rdata = '0; obi_err = 1'b0; obi_rid = '0;
        #1;
        check_reset_values("rst");
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Minimum-latency write.
        xfer(1'b1, 32'h0105_0010, 32'hDEAD_BEEF, 4'b0011, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        // Read with grant delayed 5 cycles.
        xfer(1'b0, 32'h0000_0020, 32'h0, 4'b0000, 5, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        // Read returning an OBI error.
        xfer(1'b0, 32'h0000_0040, 32'h0, 4'b0000, 1, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
        // Response on the last cycle before timeout still completes normally.
        xfer(1'b0, 32'h0000_0080, 32'h0, 4'b0000, 0, TMO - 1, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0);

        // Timeout, then a stale response drained ten cycles later.
        xfer(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 0, 99, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (9) tick();
        check("drain_rready", 32'(obi_rready), 32'd1);
        check("drain_rreadypar", 32'(obi_rreadypar), 32'd0);
        obi_rvalid = 1'b1; obi_rvalidpar = 1'b0; obi_rdata = 32'h5757_5757;
        tick();
        obi_rvalid = 1'b0; obi_rvalidpar = 1'b1;
        check("drain_done_rready", 32'(obi_rready), 32'd0);
        check("drain_no_pready", 32'(PREADY), 32'd0);
        xfer(1'b1, 32'h0000_0200, 32'h1111_2222, 4'b1111, 2, 1, 32'h0, 1'b0, 1'b0, 1'b0);

        // Bad grant parity, then a clean transfer.
        xfer(1'b1, 32'h0000_0300, 32'h3333_4444, 4'b1100, 1, 0, 32'h0, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 32'h0000_0304, 32'h0, 4'b0000, 0, 0, 32'h7777_8888, 1'b0, 1'b0, 1'b0);

        // Spurious response while idle is ignored.
        obi_rvalid = 1'b1; obi_rvalidpar = 1'b0;
        tick();
        obi_rvalid = 1'b0; obi_rvalidpar = 1'b1;
        check("spur_rready", 32'(obi_rready), 32'd0);
        check("spur_pready", 32'(PREADY), 32'd0);
        check("spur_req", 32'(obi_req), 32'd0);
        tick();

        // Asynchronous reset while the request is waiting for grant.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0000_0400;
        PWDATA = 32'h9999_AAAA; PSTRB = 4'hF;
        tick();
        PENABLE = 1'b1;
        tick();
        check("pre_rst_req", 32'(obi_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_values("midrst");
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        xfer(1'b1, 32'h0000_0404, 32'hBBBB_CCCC, 4'b0101, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            bit          wr, e, bp;
            logic [31:0] a, d, r;
            logic [3:0]  s;
            int          gd, rd;
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            r  = $urandom;
            s  = 4'($urandom_range(0, 15));
            gd = $urandom_range(0, 5);
            rd = $urandom_range(0, TMO - 1);
            e  = ($urandom_range(0, 7) == 0);
            bp = ($urandom_range(0, 7) == 0);
            xfer(wr, a, d, s, gd, rd, r, e, bp, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/apb_to_obi_bridge.md
Name: apb_to_obi_bridge

Overview:
- APB completer on one side, single-outstanding OBI manager on the other.
- Lets an APB initiator, such as a subsystem or debug APB port, reach an OBI fabric in the same clock domain.
- Converts each APB transfer into exactly one OBI transaction and returns rdata/err as PRDATA/PSLVERR.
- Adds a configurable response timeout and OBI handshake parity checking.

Parameters:
APB_AW, 32, APB address width
APB_DW, 32, APB data width; must equal OBI_DW
OBI_AW, 32, OBI address width
OBI_DW, 32, OBI data width
OBI_IDW, 1, OBI aid/rid width
ADDR_OFFSET, 32'h0000_0000, added to PADDR to form obi_addr (modulo 2^OBI_AW)
TIMEOUT, 256, max cycles waiting for rvalid after gnt; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write
PADDR  in  APB_AW  APB address
PWDATA  in  APB_DW  APB write data
PSTRB  in  APB_DW/8  APB write strobes
PRDATA  out  APB_DW  APB read data
PREADY  out  1  APB ready
PSLVERR  out  1  APB error
obi_req, obi_reqpar  out  1 each  OBI request, odd parity (reqpar = ~req)
obi_addr  out  OBI_AW  OBI address
obi_we  out  1  OBI write enable
obi_be  out  OBI_DW/8  OBI byte enables
obi_wdata  out  OBI_DW  OBI write data
obi_aid  out  OBI_IDW  OBI transaction id, constant 0
obi_gnt, obi_gntpar  in  1 each  OBI grant and its parity
obi_rvalid, obi_rvalidpar  in  1 each  OBI response valid and its parity
obi_rready, obi_rreadypar  out  1 each  OBI response ready, parity = ~rready
obi_rdata  in  OBI_DW  OBI read data
obi_err  in  1  OBI response error
obi_rid  in  OBI_IDW  OBI response id (ignored)
par_err  out  1  one-cycle pulse on any gnt/rvalid parity mismatch

Behaviour:
- All outputs registered. Reset (async, active-high) forces: state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, obi_req=0, obi_reqpar=1, obi_rready=0, obi_rreadypar=1, addr/we/be/wdata=0, par_err=0, counter=0.
- Reset mid-transaction aborts immediately; the OBI request drops in the same cycle. System-level reset covers both sides.
- FSM states: IDLE, ADDR, RESP, DONE, DRAIN.
- IDLE:
  - On PSEL=1 and PENABLE=0 (setup phase), capture the request.
  - obi_addr = PADDR + ADDR_OFFSET, truncated or zero-extended to OBI_AW.
  - obi_we = PWRITE; obi_wdata = PWDATA.
  - obi_be = PSTRB for writes; obi_be = all-ones for reads.
  - Next state ADDR, with obi_req=1 in the next cycle.
- ADDR:
  - obi_req held high and address-phase signals held stable until obi_gnt=1. There is no timeout here, per the OBI rule that req is never retracted.
  - On gnt: obi_req=0, obi_rready=1, go to RESP, clear the counter.
- RESP:
  - On obi_rvalid=1: latch PRDATA = rdata for reads, 0 for writes; PSLVERR = obi_err OR parity-error flag; go to DONE.
  - Otherwise the counter increments. When counter == TIMEOUT-1 (TIMEOUT != 0): PSLVERR=1, PRDATA=0, go to DONE, and mark the drain flag.
- DONE:
  - PREADY=1 for exactly one cycle; rready=0 (1 if the drain flag is set).
  - Next state DRAIN if the drain flag is set, else IDLE. PREADY/PSLVERR return to 0.
- DRAIN:
  - obi_rready=1; wait for the stale obi_rvalid, then go to IDLE.
  - An APB setup arriving during DRAIN is not captured. It is sampled on return to IDLE only while PSEL=1 and PENABLE=0. A master already in the access phase sees PREADY=0; this case is accepted as a stall and is not legal traffic.
- Minimum latency with gnt and rvalid each arriving one cycle after being expected:
  - Setup T0, req T1 (gnt), rvalid T2, PREADY T3.
  - APB transfer totals 4 cycles.
- Parity:
  - Each cycle in ADDR/RESP/DRAIN, check gntpar == ~gnt and rvalidpar == ~rvalid.
  - On mismatch: pulse par_err and set a sticky per-transfer flag (cleared in IDLE) that forces PSLVERR=1.
  - The handshake still proceeds on the non-parity signal.
- Spurious obi_rvalid in IDLE/ADDR/DONE: ignored (rready=0), no state change.
- Deviation handling: PSEL/PENABLE are not re-checked after capture. The transaction always completes on OBI, and DONE always lasts one cycle.
- Width rule: APB_DW must equal OBI_DW, enforced by an elaboration-time check.

Decomposition:
- Package apb_obi_bridge_pkg holds:
  - bridge_state_e enum (IDLE, ADDR, RESP, DONE, DRAIN)
  - parity helper function
  - localparam for counter width, $clog2(TIMEOUT+1)
- Sub-module apb_obi_timeout_cnt: clear/enable/expire counter, TIMEOUT=0 never expires.

Test Plan:
- Write PADDR=0x0105_0010, PWDATA=0xDEADBEEF, PSTRB=4'b0011, gnt at T1, rvalid at T2 -> obi_addr=0x0105_0010, be=0011, we=1, PREADY at T3, PSLVERR=0.
- Read with ADDR_OFFSET=0x1000, PADDR=0x20; gnt delayed 5 cycles; rdata=0x12345678 -> req held 6 cycles, obi_addr=0x1020, be=1111, PRDATA=0x12345678.
- Read with obi_err=1 on rvalid -> PSLVERR=1, PRDATA=0x0000_0000 is not required but PREADY is a one-cycle pulse.
- TIMEOUT=4, gnt given, no rvalid -> PREADY/PSLVERR after 4 RESP cycles. Stale rvalid 10 cycles later is drained (rready=1), then the next APB transfer completes normally.
- gntpar=gnt (bad parity) during grant -> par_err pulses once, transfer completes with PSLVERR=1. The next clean transfer has PSLVERR=0.
- Assert reset while in ADDR with req=1 -> obi_req=0, obi_reqpar=1 asynchronously. After release, a new write completes normally.
